// File: rtl/adc_serial_rx_if.sv
// adc_serial_rx_if: ADC serial pins plus request and sample stream of the serial ADC reader.
interface adc_serial_rx_if #(parameter int DATA_BITS = 12);
    logic start;
    logic en;
    logic cs_n;
    logic sclk;
    logic sdata;
    logic [DATA_BITS-1:0] sample;
    logic sample_valid;
    logic frame_err;
    logic busy;
    modport master (
        input start, en, sdata,
        output cs_n, sclk, sample, sample_valid, frame_err, busy
    );
    modport slave (
        output start, en, sdata,
        input cs_n, sclk, sample, sample_valid, frame_err, busy
    );
endinterface

// File: rtl/adc_serial_rx.sv
// adc_serial_rx: drives cs_n/sclk to a serial ADC, shifts in a frame and strobes out the sample.
module adc_serial_rx #(
    parameter int CLK_DIV      = 4,
    parameter int FRAME_BITS   = 16,
    parameter int DATA_BITS    = 12,
    parameter int QUIET_CYCLES = 8
) (
    input logic clk,
    input logic rst_n,
    adc_serial_rx_if.master bus
);
    localparam int PW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam int QW = $clog2(QUIET_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, CONV, QUIET} state_t;
    state_t state, state_next;
    logic [PW-1:0] phase;
    logic [BW-1:0] bit_cnt;
    logic [QW-1:0] quiet_cnt;
    logic [FRAME_BITS-1:0] shift;
    logic phase_end, frame_done, quiet_done;
    always_comb begin
        phase_end  = phase == PW'(CLK_DIV - 1);
        // frame ends after the high phase that follows the last rising edge
        frame_done = phase_end && bus.sclk && bit_cnt == BW'(FRAME_BITS);
        quiet_done = quiet_cnt == QW'(QUIET_CYCLES - 1);
        state_next = state == IDLE  ? ((bus.start || bus.en) ? CONV : IDLE) :
                     state == CONV  ? (frame_done ? QUIET : CONV) :
                     state == QUIET ? (quiet_done ? (bus.en ? CONV : IDLE) : QUIET) : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_next;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.cs_n         <= 1'b1;
            bus.sclk         <= 1'b1;
            bus.sample       <= '0;
            bus.sample_valid <= 1'b0;
            bus.frame_err    <= 1'b0;
            bus.busy         <= 1'b0;
            phase            <= '0;
            bit_cnt          <= '0;
            quiet_cnt        <= '0;
            shift            <= '0;
        end else begin
            bus.sample_valid <= 1'b0;
            bus.frame_err    <= 1'b0;
            if (state != CONV && state_next == CONV) begin
                bus.cs_n <= 1'b0;
                bus.sclk <= 1'b1;
                bus.busy <= 1'b1;
                phase    <= '0;
                bit_cnt  <= '0;
            end else if (state == CONV) begin
                phase <= phase_end ? '0 : phase + 1'b1;
                if (phase_end && !bus.sclk) begin
                    bus.sclk <= 1'b1;
                    shift    <= {shift[FRAME_BITS-2:0], bus.sdata};
                    bit_cnt  <= bit_cnt + 1'b1;
                end else if (phase_end && !frame_done) begin
                    bus.sclk <= 1'b0;
                end
                if (frame_done) begin
                    bus.cs_n         <= 1'b1;
                    bus.sample       <= shift[DATA_BITS-1:0];
                    bus.sample_valid <= 1'b1;
                    bus.frame_err    <= |shift[FRAME_BITS-1:DATA_BITS];
                    quiet_cnt        <= '0;
                end
            end else if (state == QUIET) begin
                quiet_cnt <= quiet_cnt + 1'b1;
                if (quiet_done) bus.busy <= 1'b0;
            end
        end
    end
endmodule

// File: doc/adc_serial_rx.md
Name: adc_serial_rx

Overview:
- Serial ADC reader for the ultrasound echo receive path.
- It is the receive counterpart to the team's DAC serial writer (SYNC/SCLK/DIN).
- Drives chip-select and serial clock to an external SPI-style ADC, such as a 12-bit part with 4 leading zeros in a 16-bit frame.
- Shifts in the serial data, checks the frame and presents a parallel sample with a one-cycle valid strobe to the downstream time-of-flight logic.

Parameters:
- CLK_DIV, 4: clk cycles per sclk half-period (>=1).
- FRAME_BITS, 16: sclk cycles per conversion frame.
- DATA_BITS, 12: significant LSBs of the frame; FRAME_BITS-DATA_BITS leading bits must be zero.
- QUIET_CYCLES, 8: minimum clk cycles with cs_n high between frames (>=1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-shot conversion request, sampled in IDLE only.
- en  input  1  continuous mode; while high, frames repeat back-to-back after QUIET.
- cs_n  output  1  ADC chip select, active low.
- sclk  output  1  ADC serial clock, idles high.
- sdata  input  1  ADC serial data, MSB first; ADC changes it after sclk falls.
- sample  output  DATA_BITS  last captured sample, held until the next valid.
- sample_valid  output  1  one-cycle strobe: sample updated.
- frame_err  output  1  one-cycle strobe coincident with sample_valid: leading bits were not all zero.
- busy  output  1  high in CONV or QUIET.

Behaviour:
- Clock and reset: one clock domain. rst_n is asynchronous and active-low; all flops clear immediately on assertion.
- Reset values:
  - cs_n=1, sclk=1.
  - sample=0, sample_valid=0, frame_err=0, busy=0.
  - State=IDLE; counters and shift register = 0.
- States: IDLE, CONV, QUIET.
- IDLE:
  - If start or en is high, go to CONV on the next edge.
  - On that same edge: cs_n<=0, busy<=1, bit counter=0, phase counter=0.
- CONV:
  - sclk toggles every CLK_DIV clk cycles, starting with a fall CLK_DIV cycles after cs_n falls.
  - Low phase and high phase are each CLK_DIV cycles.
  - On each clk edge where sclk goes 0->1, sdata is shifted into the LSB of a FRAME_BITS shift register and the bit counter increments.
  - After the FRAME_BITS-th rising edge plus a full high phase of CLK_DIV cycles, go to QUIET: cs_n<=1, sclk stays 1.
  - cs_n is low for exactly (2*FRAME_BITS+1)*CLK_DIV clk cycles.
- On CONV->QUIET entry (same edge cs_n rises):
  - sample <= shift[DATA_BITS-1:0].
  - sample_valid <= 1.
  - frame_err <= |shift[FRAME_BITS-1:DATA_BITS].
  - Both strobes are high for exactly one cycle. A frame with frame_err still updates sample.
- QUIET:
  - Stay for QUIET_CYCLES cycles.
  - Then, if en=1, go to CONV directly (cs_n<=0, busy stays 1).
  - Otherwise go to IDLE with busy<=0.
- start handling: start is ignored outside IDLE. It is not queued.
- Boundary conditions:
  - start and en both high in IDLE: one frame starts.
  - en dropped mid-CONV: the current frame completes normally, then the block goes to IDLE after QUIET.
  - Reset mid-frame: cs_n rises and sclk goes high asynchronously; no sample_valid is produced for the partial frame; the block restarts from IDLE after reset release.
- sdata is sampled directly; no synchronizer is needed because sclk is derived from clk.
- Throughput in continuous mode: one sample per (2*FRAME_BITS+1)*CLK_DIV + QUIET_CYCLES clk cycles.

Test Plan:
1. Single shot, defaults with CLK_DIV=2, ADC model returns frame 0x0ABC.
   - Pulse start one cycle in IDLE.
   - cs_n falls 1 cycle later; 16 sclk rising edges.
   - cs_n low for 66 cycles.
   - On the cs_n rise edge: sample=0xABC, sample_valid=1 for one cycle, frame_err=0.
   - busy falls 8 cycles later.
2. Frame error: model returns 0x8123.
   - sample=0x123, sample_valid=1 and frame_err=1 in the same cycle.
3. Continuous mode: en=1, model returns 0x0001, 0x0FFF, 0x0800.
   - Three valid strobes 74 cycles apart with samples 0x001, 0xFFF, 0x800.
   - cs_n high for exactly 8 cycles between frames.
   - busy never drops.
4. Start while busy: pulse start at the 10th cycle of CONV.
   - No extra frame occurs.
   - Exactly one sample_valid, then IDLE.
5. Reset mid-frame: assert rst_n=0 after 5 sclk rising edges.
   - cs_n=1, sclk=1 and all outputs 0 in the same cycle.
   - After release, no sample_valid appears until a new start.
   - The next frame (0x0555) gives sample=0x555.
6. en deasserted mid-frame: frame completes, one valid strobe, then the block returns to IDLE with busy=0 after 8 quiet cycles.
